uart_komut_denetleyici: RTL and testbench

//  Sequences the UART TX engine and decodes UART RX bytes for the calendar top level.
//  'T': snapshots the date/time registers and streams "DD.MM.YYYY HH:MM:SS" (+CR LF) one byte per TX handshake.
//  'G'+14 ASCII digits (DDMMYYYYHHMMSS): range-checks the digits, then issues a one-cycle set request to the calendar.

---
 rtl/uart_komut_denetleyici.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_uart_komut_denetleyici.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_komut_denetleyici.sv
// uart_komut_denetleyici: UART report/command sequencer for the calendar.
// 'T' streams a date/time report; 'G'+14 digits loads a new date/time.
module uart_komut_denetleyici #(
  parameter int unsigned BAYT_ZAMAN_ASIMI = 100_000_000,
  parameter bit          SATIR_SONU       = 1'b1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_busy,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  input  logic [4:0]  gun,
  input  logic [3:0]  ay,
  input  logic [11:0] yil,
  input  logic [4:0]  saat,
  input  logic [5:0]  dakika,
  input  logic [5:0]  saniye,
  output logic        ayar_gecerli,
  output logic [4:0]  ayar_gun,
  output logic [3:0]  ayar_ay,
  output logic [11:0] ayar_yil,
  output logic [4:0]  ayar_saat,
  output logic [5:0]  ayar_dakika,
  output logic [5:0]  ayar_saniye,
  output logic        rapor_mesgul,
  output logic        hata
);
  localparam int unsigned TW =
    (BAYT_ZAMAN_ASIMI > 1) ? $clog2(BAYT_ZAMAN_ASIMI) : 1;
  localparam logic [TW-1:0] ZA_SON = TW'(BAYT_ZAMAN_ASIMI - 1);
  localparam logic [4:0] SON_IDX = SATIR_SONU ? 5'd20 : 5'd18;
  localparam logic [7:0] C_T = 8'h54;
  localparam logic [7:0] C_G = 8'h47;
  localparam logic [7:0] C_0 = 8'h30;

  typedef enum logic [1:0] {
    R_BOS, R_GONDER, R_BEKLE_MESGUL, R_BEKLE_BOS
  } rapor_e;
  typedef enum logic [1:0] {
    K_BOS, K_TOPLA, K_DOGRULA
  } komut_e;

  rapor_e r_rs, w_rs_n;
  komut_e r_ks, w_ks_n;

  logic [4:0]    r_idx, w_idx_n;
  logic [TW-1:0] r_rz, w_rz_n;
  logic          r_tx_en, w_tx_en_n;
  logic [7:0]    r_tx_data, w_tx_data_n;
  logic          w_yakala;
  logic [7:0]    w_bayt;
  logic          w_t_baslat;

  logic [4:0]  r_s_gun;
  logic [3:0]  r_s_ay;
  logic [11:0] r_s_yil;
  logic [4:0]  r_s_saat;
  logic [5:0]  r_s_dk;
  logic [5:0]  r_s_sn;

  logic [3:0]    r_say, w_say_n;
  logic [TW-1:0] r_kz, w_kz_n;
  logic [6:0]    r_a_gun, w_a_gun_n;
  logic [6:0]    r_a_ay, w_a_ay_n;
  logic [13:0]   r_a_yil, w_a_yil_n;
  logic [6:0]    r_a_saat, w_a_saat_n;
  logic [6:0]    r_a_dk, w_a_dk_n;
  logic [6:0]    r_a_sn, w_a_sn_n;
  logic          w_rakam;
  logic [3:0]    w_deger;
  logic          w_uygun;
  logic          r_hata, w_hata_n;
  logic          r_gec, w_gec_n;

  logic [4:0]  r_ayar_gun;
  logic [3:0]  r_ayar_ay;
  logic [11:0] r_ayar_yil;
  logic [4:0]  r_ayar_saat;
  logic [5:0]  r_ayar_dk;
  logic [5:0]  r_ayar_sn;

  // A 'T' inside a 'G' sequence aborts the command and starts nothing.
  assign w_t_baslat = rx_valid && (rx_data == C_T) && (r_ks != K_TOPLA);
  assign w_rakam = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign w_deger = rx_data[3:0];

  always_comb begin
    w_bayt = 8'h00;
    case (r_idx)
      5'd0:    w_bayt = C_0 + 8'(r_s_gun / 5'd10);
      5'd1:    w_bayt = C_0 + 8'(r_s_gun % 5'd10);
      5'd2:    w_bayt = 8'h2E;
      5'd3:    w_bayt = C_0 + 8'(r_s_ay / 4'd10);
      5'd4:    w_bayt = C_0 + 8'(r_s_ay % 4'd10);
      5'd5:    w_bayt = 8'h2E;
      5'd6:    w_bayt = C_0 + 8'(r_s_yil / 12'd1000);
      5'd7:    w_bayt = C_0 + 8'((r_s_yil / 12'd100) % 12'd10);
      5'd8:    w_bayt = C_0 + 8'((r_s_yil / 12'd10) % 12'd10);
      5'd9:    w_bayt = C_0 + 8'(r_s_yil % 12'd10);
      5'd10:   w_bayt = 8'h20;
      5'd11:   w_bayt = C_0 + 8'(r_s_saat / 5'd10);
      5'd12:   w_bayt = C_0 + 8'(r_s_saat % 5'd10);
      5'd13:   w_bayt = 8'h3A;
      5'd14:   w_bayt = C_0 + 8'(r_s_dk / 6'd10);
      5'd15:   w_bayt = C_0 + 8'(r_s_dk % 6'd10);
      5'd16:   w_bayt = 8'h3A;
      5'd17:   w_bayt = C_0 + 8'(r_s_sn / 6'd10);
      5'd18:   w_bayt = C_0 + 8'(r_s_sn % 6'd10);
      5'd19:   w_bayt = 8'h0D;
      5'd20:   w_bayt = 8'h0A;
      default: w_bayt = 8'h00;
    endcase
  end

  always_comb begin
    w_rs_n      = r_rs;
    w_idx_n     = r_idx;
    w_rz_n      = '0;
    w_yakala    = 1'b0;
    w_tx_en_n   = 1'b0;
    w_tx_data_n = r_tx_data;
    unique case (r_rs)
      R_BOS: begin
        if (w_t_baslat) begin
          w_rs_n   = R_GONDER;
          w_idx_n  = '0;
          w_yakala = 1'b1;
        end
      end
      R_GONDER: begin
        if (!tx_busy) begin
          w_tx_en_n   = 1'b1;
          w_tx_data_n = w_bayt;
          w_rs_n      = R_BEKLE_MESGUL;
        end
      end
      R_BEKLE_MESGUL: begin
        if (tx_busy || (r_rz == ZA_SON))
          w_rs_n = R_BEKLE_BOS;
        else
          w_rz_n = r_rz + TW'(1);
      end
      R_BEKLE_BOS: begin
        if (!tx_busy) begin
          if (r_idx == SON_IDX) begin
            w_rs_n = R_BOS;
          end else begin
            w_idx_n = r_idx + 5'd1;
            w_rs_n  = R_GONDER;
          end
        end
      end
      default: w_rs_n = R_BOS;
    endcase
  end

  assign w_uygun = (r_a_gun >= 7'd1) && (r_a_gun <= 7'd31) &&
                   (r_a_ay >= 7'd1) && (r_a_ay <= 7'd12) &&
                   (r_a_yil <= 14'd4095) && (r_a_saat <= 7'd23) &&
                   (r_a_dk <= 7'd59) && (r_a_sn <= 7'd59);

  always_comb begin
    w_ks_n     = r_ks;
    w_say_n    = r_say;
    w_kz_n     = r_kz;
    w_a_gun_n  = r_a_gun;
    w_a_ay_n   = r_a_ay;
    w_a_yil_n  = r_a_yil;
    w_a_saat_n = r_a_saat;
    w_a_dk_n   = r_a_dk;
    w_a_sn_n   = r_a_sn;
    w_hata_n   = 1'b0;
    w_gec_n    = 1'b0;
    unique case (r_ks)
      K_BOS: begin
        if (rx_valid && (rx_data == C_G)) begin
          w_ks_n     = K_TOPLA;
          w_say_n    = '0;
          w_kz_n     = '0;
          w_a_gun_n  = '0;
          w_a_ay_n   = '0;
          w_a_yil_n  = '0;
          w_a_saat_n = '0;
          w_a_dk_n   = '0;
          w_a_sn_n   = '0;
        end
      end
      K_TOPLA: begin
        if (rx_valid && w_rakam) begin
          w_kz_n  = '0;
          w_say_n = r_say + 4'd1;
          // Digit order DD MM YYYY HH MM SS
          unique case (1'b1)
            (r_say < 4'd2):
              w_a_gun_n = r_a_gun * 7'd10 + {3'b0, w_deger};
            (r_say inside {[4'd2:4'd3]}):
              w_a_ay_n = r_a_ay * 7'd10 + {3'b0, w_deger};
            (r_say inside {[4'd4:4'd7]}):
              w_a_yil_n = r_a_yil * 14'd10 + {10'b0, w_deger};
            (r_say inside {[4'd8:4'd9]}):
              w_a_saat_n = r_a_saat * 7'd10 + {3'b0, w_deger};
            (r_say inside {[4'd10:4'd11]}):
              w_a_dk_n = r_a_dk * 7'd10 + {3'b0, w_deger};
            default:
              w_a_sn_n = r_a_sn * 7'd10 + {3'b0, w_deger};
          endcase
          if (r_say == 4'd13)
            w_ks_n = K_DOGRULA;
        end else if (rx_valid || (r_kz == ZA_SON)) begin
          w_hata_n = 1'b1;
          w_ks_n   = K_BOS;
        end else begin
          w_kz_n = r_kz + TW'(1);
        end
      end
      K_DOGRULA: begin
        w_ks_n   = K_BOS;
        w_gec_n  = w_uygun;
        w_hata_n = !w_uygun;
      end
      default: w_ks_n = K_BOS;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_rs <= R_BOS;
      r_ks <= K_BOS;
    end else begin
      r_rs <= w_rs_n;
      r_ks <= w_ks_n;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_idx       <= '0;
      r_rz        <= '0;
      r_tx_en     <= 1'b0;
      r_tx_data   <= '0;
      r_s_gun     <= '0;
      r_s_ay      <= '0;
      r_s_yil     <= '0;
      r_s_saat    <= '0;
      r_s_dk      <= '0;
      r_s_sn      <= '0;
      r_say       <= '0;
      r_kz        <= '0;
      r_a_gun     <= '0;
      r_a_ay      <= '0;
      r_a_yil     <= '0;
      r_a_saat    <= '0;
      r_a_dk      <= '0;
      r_a_sn      <= '0;
      r_hata      <= 1'b0;
      r_gec       <= 1'b0;
      r_ayar_gun  <= '0;
      r_ayar_ay   <= '0;
      r_ayar_yil  <= '0;
      r_ayar_saat <= '0;
      r_ayar_dk   <= '0;
      r_ayar_sn   <= '0;
    end else begin
      r_idx     <= w_idx_n;
      r_rz      <= w_rz_n;
      r_tx_en   <= w_tx_en_n;
      r_tx_data <= w_tx_data_n;
      if (w_yakala) begin
        r_s_gun  <= gun;
        r_s_ay   <= ay;
        r_s_yil  <= yil;
        r_s_saat <= saat;
        r_s_dk   <= dakika;
        r_s_sn   <= saniye;
      end
      r_say    <= w_say_n;
      r_kz     <= w_kz_n;
      r_a_gun  <= w_a_gun_n;
      r_a_ay   <= w_a_ay_n;
      r_a_yil  <= w_a_yil_n;
      r_a_saat <= w_a_saat_n;
      r_a_dk   <= w_a_dk_n;
      r_a_sn   <= w_a_sn_n;
      r_hata   <= w_hata_n;
      r_gec    <= w_gec_n;
      if (w_gec_n) begin
        r_ayar_gun  <= r_a_gun[4:0];
        r_ayar_ay   <= r_a_ay[3:0];
        r_ayar_yil  <= r_a_yil[11:0];
        r_ayar_saat <= r_a_saat[4:0];
        r_ayar_dk   <= r_a_dk[5:0];
        r_ayar_sn   <= r_a_sn[5:0];
      end
    end
  end

  assign tx_en        = r_tx_en;
  assign tx_data      = r_tx_data;
  assign rapor_mesgul = (r_rs != R_BOS);
  assign hata         = r_hata;
  assign ayar_gecerli = r_gec;
  assign ayar_gun     = r_ayar_gun;
  assign ayar_ay      = r_ayar_ay;
  assign ayar_yil     = r_ayar_yil;
  assign ayar_saat    = r_ayar_saat;
  assign ayar_dakika  = r_ayar_dk;
  assign ayar_saniye  = r_ayar_sn;

endmodule

// File: tb/tb_uart_komut_denetleyici.sv
// tb_uart_komut_denetleyici: directed bench for uart_komut_denetleyici.
// TX model holds busy for 10 cycles after each tx_en.
module tb_uart_komut_denetleyici;
  localparam int unsigned N = 1000;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_busy;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic [4:0]  gun = 5'd0;
  logic [3:0]  ay = 4'd0;
  logic [11:0] yil = 12'd0;
  logic [4:0]  saat = 5'd0;
  logic [5:0]  dakika = 6'd0;
  logic [5:0]  saniye = 6'd0;
  logic        ayar_gecerli;
  logic [4:0]  ayar_gun;
  logic [3:0]  ayar_ay;
  logic [11:0] ayar_yil;
  logic [4:0]  ayar_saat;
  logic [5:0]  ayar_dakika;
  logic [5:0]  ayar_saniye;
  logic        rapor_mesgul;
  logic        hata;

  uart_komut_denetleyici #(
    .BAYT_ZAMAN_ASIMI(N),
    .SATIR_SONU(1'b1)
  ) dut (
    .CLK(CLK), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data),
    .gun(gun), .ay(ay), .yil(yil),
    .saat(saat), .dakika(dakika), .saniye(saniye),
    .ayar_gecerli(ayar_gecerli),
    .ayar_gun(ayar_gun), .ayar_ay(ayar_ay), .ayar_yil(ayar_yil),
    .ayar_saat(ayar_saat), .ayar_dakika(ayar_dakika),
    .ayar_saniye(ayar_saniye),
    .rapor_mesgul(rapor_mesgul), .hata(hata)
  );

  always #5 CLK = ~CLK;

  int toplam = 0;
  int gecen = 0;
  int hatali = 0;
  int busy_say = 0;
  int cakisma = 0;
  int hata_say = 0;
  int gec_say = 0;
  logic [7:0] txq [$];

  assign tx_busy = (busy_say != 0);

  always @(negedge CLK) begin
    if (tx_en) begin
      txq.push_back(tx_data);
      if (busy_say != 0) cakisma++;
      busy_say = 10;
    end else if (busy_say != 0) begin
      busy_say--;
    end
    if (hata) hata_say++;
    if (ayar_gecerli) gec_say++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    toplam++;
    assert (obs === exp) gecen++;
    else begin
      hatali++;
      $error("FAIL %s: gozlenen=%0d beklenen=%0d", tag, obs, exp);
    end
  endtask

  task automatic adim();
    @(posedge CLK);
    #1;
  endtask

  task automatic bayt_gonder(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    adim();
    rx_valid = 1'b0;
  endtask

  task automatic g_komut(input string s);
    bayt_gonder(8'h47);
    for (int i = 0; i < s.len(); i++) bayt_gonder(s[i]);
  endtask

  task automatic rapor_bekle(input string tag);
    int k = 0;
    while (rapor_mesgul && k < 2000) begin
      adim();
      k++;
    end
    chk({tag, "_bitti"}, 32'(rapor_mesgul), 0);
  endtask

  task automatic rapor_kontrol(input string tag, input string s,
                               input int n);
    logic [7:0] e;
    chk({tag, "_adet"}, txq.size(), n);
    for (int i = 0; i < n && i < txq.size(); i++) begin
      if (i < 19)       e = s[i];
      else if (i == 19) e = 8'h0D;
      else              e = 8'h0A;
      chk($sformatf("%s_bayt%0d", tag, i), 32'(txq[i]), 32'(e));
    end
  endtask

  task automatic ayar_kontrol(input string tag, input int g, input int a,
                              input int y, input int h, input int d,
                              input int s);
    chk({tag, "_gun"}, 32'(ayar_gun), g);
    chk({tag, "_ay"}, 32'(ayar_ay), a);
    chk({tag, "_yil"}, 32'(ayar_yil), y);
    chk({tag, "_saat"}, 32'(ayar_saat), h);
    chk({tag, "_dakika"}, 32'(ayar_dakika), d);
    chk({tag, "_saniye"}, 32'(ayar_saniye), s);
  endtask

  task automatic gecerli_komut(input string tag, input string s,
                               input int g, input int a, input int y,
                               input int h, input int d, input int sn);
    int h0 = hata_say;
    g_komut(s);
    chk({tag, "_gec_erken"}, 32'(ayar_gecerli), 0);
    adim();
    chk({tag, "_gec"}, 32'(ayar_gecerli), 1);
    ayar_kontrol(tag, g, a, y, h, d, sn);
    adim();
    chk({tag, "_gec_bitti"}, 32'(ayar_gecerli), 0);
    chk({tag, "_hata_yok"}, hata_say, h0);
  endtask

  task automatic hatali_komut(input string tag, input string s);
    int g0 = gec_say;
    g_komut(s);
    adim();
    chk({tag, "_hata"}, 32'(hata), 1);
    adim();
    chk({tag, "_hata_bitti"}, 32'(hata), 0);
    chk({tag, "_gec_yok"}, gec_say, g0);
  endtask

  string beklenen = "30.07.2024 18:30:05";
  string ara_s = "G15062030121314";
  int h0;
  int g0;
  int k;

  initial begin
    gun = 5'd30; ay = 4'd7; yil = 12'd2024;
    saat = 5'd18; dakika = 6'd30; saniye = 6'd5;
    repeat (3) adim();
    chk("rst_tx_en", 32'(tx_en), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_gec", 32'(ayar_gecerli), 0);
    chk("rst_mesgul", 32'(rapor_mesgul), 0);
    chk("rst_hata", 32'(hata), 0);
    chk("rst_ayar_yil", 32'(ayar_yil), 0);
    reset = 1'b0;
    adim();

    // Basic report and first-byte latency
    bayt_gonder(8'h54);
    chk("t_mesgul", 32'(rapor_mesgul), 1);
    chk("t_tx_en_erken", 32'(tx_en), 0);
    adim();
    chk("t_tx_en_ilk", 32'(tx_en), 1);
    chk("t_tx_data_ilk", 32'(tx_data), 32'h33);
    rapor_bekle("r1");
    rapor_kontrol("r1", beklenen, 21);
    chk("r1_hata_yok", hata_say, 0);

    gecerli_komut("g1", "01012025000000", 1, 1, 2025, 0, 0, 0);
    gecerli_komut("g2", "29021999235959", 29, 2, 1999, 23, 59, 59);
    gecerli_komut("g3", "31124095235959", 31, 12, 4095, 23, 59, 59);

    hatali_komut("gun32", "32012025000000");
    hatali_komut("gun0", "00012025000000");
    hatali_komut("ay13", "01130001000000");
    hatali_komut("yil4096", "01014096000000");
    hatali_komut("saat24", "01010001240000");
    hatali_komut("dk60", "01010001006000");
    ayar_kontrol("red_sonra", 31, 12, 4095, 23, 59, 59);

    // Non-digit abort: hata on the 'A' byte itself
    g0 = gec_say;
    g_komut("0101A");
    chk("harf_hata", 32'(hata), 1);
    adim();
    chk("harf_hata_bitti", 32'(hata), 0);
    chk("harf_gec_yok", gec_say, g0);

    // Inter-byte timeout
    h0 = hata_say;
    g_komut("0101");
    repeat (N - 5) adim();
    chk("za_erken", hata_say, h0);
    repeat (10) adim();
    chk("za_hata", hata_say, h0 + 1);
    txq.delete();
    bayt_gonder(8'h54);
    rapor_bekle("r2");
    rapor_kontrol("r2", beklenen, 21);

    // Second 'T' and a 'G' command interleaved with a report
    txq.delete();
    g0 = gec_say;
    h0 = hata_say;
    bayt_gonder(8'h54);
    repeat (5) adim();
    bayt_gonder(8'h54);
    repeat (3) adim();
    for (int i = 0; i < ara_s.len(); i++) begin
      bayt_gonder(ara_s[i]);
      repeat (2) adim();
    end
    rapor_bekle("r3");
    rapor_kontrol("r3", beklenen, 21);
    repeat (300) adim();
    chk("r3_tek_rapor", txq.size(), 21);
    chk("r3_gec", gec_say, g0 + 1);
    chk("r3_hata_yok", hata_say, h0);
    ayar_kontrol("r3", 15, 6, 2030, 12, 13, 14);

    // Snapshot isolation, partial 'G', reset at byte 7
    txq.delete();
    h0 = hata_say;
    bayt_gonder(8'h54);
    gun = 5'd1; ay = 4'd1; yil = 12'd0;
    saat = 5'd0; dakika = 6'd0; saniye = 6'd0;
    bayt_gonder(8'h47);
    bayt_gonder(8'h31);
    k = 0;
    while (!(tx_en && txq.size() == 6) && k < 2000) begin
      adim();
      k++;
    end
    chk("r4_bayt7", 32'(tx_en), 1);
    reset = 1'b1;
    #1;
    chk("r4_rst_tx_en", 32'(tx_en), 0);
    chk("r4_rst_mesgul", 32'(rapor_mesgul), 0);
    rapor_kontrol("r4", beklenen, 6);
    adim();
    reset = 1'b0;
    repeat (N + 100) adim();
    chk("r4_ek_bayt_yok", txq.size(), 6);
    chk("r4_hata_yok", hata_say, h0);
    chk("r4_ayar_sifir", 32'(ayar_yil), 0);
    chk("r4_mesgul", 32'(rapor_mesgul), 0);

    chk("tx_en_mesgulken", cakisma, 0);

    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

endmodule
